ysyx_axi_sram: RTL and testbench

YSYX_AXI_SRAM -- requirements
Module: ysyx_axi_sram

---
 rtl/ysyx_axi_sram.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_ysyx_axi_sram.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_axi_sram.sv
// ysyx_axi_sram: AXI4 slave backed by a 64-bit wide on-chip SRAM.
// Read and write channels run independent FSMs, each holding one burst in flight.
// The memory is split into eight byte lanes so that wstrb maps onto a per-lane write enable.
// Reads are registered and read-first: a read and a write to the same word in the same
// cycle return the old contents.
module ysyx_axi_sram #(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] BASE    = 32'h8000_0000,
  parameter int                DEPTH_W = 12,
  parameter int                RD_LAT  = 1
) (
  input  logic              clock,
  input  logic              reset,
  // AR channel
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [3:0]        arid,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  // R channel
  output logic              rvalid,
  input  logic              rready,
  output logic [63:0]       rdata,
  output logic [3:0]        rid,
  output logic [1:0]        rresp,
  output logic              rlast,
  // AW channel
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [3:0]        awid,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  // W channel
  input  logic              wvalid,
  output logic              wready,
  input  logic [63:0]       wdata,
  input  logic [7:0]        wstrb,
  input  logic              wlast,
  // B channel
  output logic              bvalid,
  input  logic              bready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp
);

  localparam int DEPTH = 1 << DEPTH_W;

  // True when the byte address falls inside the window served by this SRAM.
  function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] w_off;
    logic [ADDR_W:0] w_lim;
    w_off = {1'b0, a} - {1'b0, BASE};
    w_lim = '0;
    w_lim[DEPTH_W+3] = 1'b1;
    return (a >= BASE) && (w_off < w_lim);
  endfunction

  // Address of the following beat: INCR steps by the transfer size (capped at 8 bytes),
  // FIXED and the error burst types stay put.
  function automatic logic [ADDR_W-1:0] f_next(input logic [ADDR_W-1:0] a,
                                              input logic [2:0] size,
                                              input logic [1:0] burst);
    logic [ADDR_W-1:0] w_step;
    w_step = '0;
    case (size)
      3'd0:    w_step[0] = 1'b1;
      3'd1:    w_step[1] = 1'b1;
      3'd2:    w_step[2] = 1'b1;
      default: w_step[3] = 1'b1;
    endcase
    return (burst == 2'b01) ? (a + w_step) : a;
  endfunction

  // WRAP (2'b10) and the reserved encoding (2'b11) are both rejected.
  function automatic logic f_bad_burst(input logic [1:0] burst);
    return burst[1];
  endfunction

  // ---------------------------------------------------------------- read side
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;

  rd_state_t         r_rd_state;
  rd_state_t         w_rd_state_next;
  logic [ADDR_W-1:0] r_raddr;
  logic [3:0]        r_rid;
  logic [7:0]        r_rlen;
  logic [2:0]        r_rsize;
  logic [1:0]        r_rburst;
  logic [7:0]        r_rcnt;
  logic [3:0]        r_rlat;
  logic [1:0]        r_rresp;
  logic              r_rlast;
  logic              r_rzero;

  logic              w_arready;
  logic              w_rvalid;
  logic              w_ar_hs;
  logic              w_rload;
  logic [ADDR_W-1:0] w_ld_addr;
  logic [1:0]        w_ld_burst;
  logic [7:0]        w_ld_len;
  logic [7:0]        w_ld_cnt;
  logic [1:0]        w_ld_resp;
  logic [DEPTH_W-1:0] w_ld_idx;
  logic [63:0]       w_rword;

  assign w_arready = (r_rd_state == R_IDLE) && !reset;
  assign w_rvalid  = (r_rd_state == R_DATA) && !reset;
  assign w_ar_hs   = w_arready && arvalid;

  assign arready = w_arready;
  assign rvalid  = w_rvalid;
  assign rdata   = r_rzero ? 64'd0 : w_rword;
  assign rid     = r_rid;
  assign rresp   = w_rvalid ? r_rresp : 2'b00;
  assign rlast   = w_rvalid && r_rlast;

  // Read FSM next state; w_rload marks the cycles where a new beat is fetched into the R registers.
  always_comb begin
    w_rd_state_next = r_rd_state;
    w_rload         = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        if (arvalid) begin
          w_rd_state_next = (RD_LAT > 0) ? R_WAIT : R_DATA;
          w_rload         = (RD_LAT == 0);
        end
      end
      R_WAIT: begin
        if (r_rlat == 4'(RD_LAT - 1)) begin
          w_rd_state_next = R_DATA;
          w_rload         = 1'b1;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (r_rlast) w_rd_state_next = R_IDLE;
          else         w_rload         = 1'b1;
        end
      end
      default: w_rd_state_next = R_IDLE;
    endcase
  end

  // Select the address/beat number of the beat being fetched and classify its response.
  always_comb begin
    w_ld_addr  = r_raddr;
    w_ld_burst = r_rburst;
    w_ld_len   = r_rlen;
    w_ld_cnt   = r_rcnt;
    if (r_rd_state == R_IDLE) begin
      w_ld_addr  = araddr;
      w_ld_burst = arburst;
      w_ld_len   = arlen;
      w_ld_cnt   = 8'd0;
    end else if (r_rd_state == R_DATA) begin
      w_ld_addr  = f_next(r_raddr, r_rsize, r_rburst);
      w_ld_cnt   = r_rcnt + 8'd1;
    end
    if (f_bad_burst(w_ld_burst))   w_ld_resp = 2'b10;
    else if (!f_in_range(w_ld_addr)) w_ld_resp = 2'b11;
    else                           w_ld_resp = 2'b00;
    w_ld_idx = w_ld_addr[DEPTH_W+2:3];
  end

  // Read FSM state, captured AR fields and the registered per-beat R sideband.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_state <= R_IDLE;
      r_raddr    <= '0;
      r_rid      <= '0;
      r_rlen     <= '0;
      r_rsize    <= '0;
      r_rburst   <= '0;
      r_rcnt     <= '0;
      r_rlat     <= '0;
      r_rresp    <= '0;
      r_rlast    <= 1'b0;
      r_rzero    <= 1'b0;
    end else begin
      r_rd_state <= w_rd_state_next;
      if (w_ar_hs) begin
        r_raddr  <= araddr;
        r_rid    <= arid;
        r_rlen   <= arlen;
        r_rsize  <= arsize;
        r_rburst <= arburst;
        r_rcnt   <= '0;
        r_rlat   <= '0;
      end
      if (r_rd_state == R_WAIT) r_rlat <= r_rlat + 4'd1;
      if (w_rload) begin
        r_rcnt  <= w_ld_cnt;
        r_rlast <= (w_ld_cnt == w_ld_len);
        r_rresp <= w_ld_resp;
        r_rzero <= (w_ld_resp != 2'b00);
        if (r_rd_state == R_DATA) r_raddr <= w_ld_addr;
      end
    end
  end

  // --------------------------------------------------------------- write side
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  wr_state_t         r_wr_state;
  wr_state_t         w_wr_state_next;
  logic [ADDR_W-1:0] r_waddr;
  logic [3:0]        r_wid;
  logic [7:0]        r_wlen;
  logic [2:0]        r_wsize;
  logic [1:0]        r_wburst;
  logic [7:0]        r_wcnt;
  logic              r_werr;
  logic              r_wdec;

  logic              w_awready;
  logic              w_wready;
  logic              w_bvalid;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_wen;
  logic [DEPTH_W-1:0] w_widx;
  logic [1:0]        w_bresp;

  assign w_awready = (r_wr_state == W_IDLE) && !reset;
  assign w_wready  = (r_wr_state == W_DATA) && !reset;
  assign w_bvalid  = (r_wr_state == W_RESP) && !reset;
  assign w_aw_hs   = w_awready && awvalid;
  assign w_w_hs    = w_wready && wvalid;
  assign w_wen     = w_w_hs && !f_bad_burst(r_wburst) && f_in_range(r_waddr);
  assign w_widx    = r_waddr[DEPTH_W+2:3];
  assign w_bresp   = r_wdec ? 2'b11 :
                     (r_werr || f_bad_burst(r_wburst)) ? 2'b10 : 2'b00;

  assign awready = w_awready;
  assign wready  = w_wready;
  assign bvalid  = w_bvalid;
  assign bid     = r_wid;
  assign bresp   = w_bvalid ? w_bresp : 2'b00;

  // Write FSM next state; the burst length, not wlast, decides when data ends.
  always_comb begin
    w_wr_state_next = r_wr_state;
    case (r_wr_state)
      W_IDLE:  if (awvalid)                      w_wr_state_next = W_DATA;
      W_DATA:  if (wvalid && (r_wcnt == r_wlen)) w_wr_state_next = W_RESP;
      W_RESP:  if (bready)                       w_wr_state_next = W_IDLE;
      default:                                   w_wr_state_next = W_IDLE;
    endcase
  end

  // Write FSM state, captured AW fields, beat counter and sticky error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_state <= W_IDLE;
      r_waddr    <= '0;
      r_wid      <= '0;
      r_wlen     <= '0;
      r_wsize    <= '0;
      r_wburst   <= '0;
      r_wcnt     <= '0;
      r_werr     <= 1'b0;
      r_wdec     <= 1'b0;
    end else begin
      r_wr_state <= w_wr_state_next;
      if (w_aw_hs) begin
        r_waddr  <= awaddr;
        r_wid    <= awid;
        r_wlen   <= awlen;
        r_wsize  <= awsize;
        r_wburst <= awburst;
        r_wcnt   <= '0;
        r_werr   <= 1'b0;
        r_wdec   <= 1'b0;
      end
      if (w_w_hs) begin
        r_waddr <= f_next(r_waddr, r_wsize, r_wburst);
        r_wcnt  <= r_wcnt + 8'd1;
        if (wlast != (r_wcnt == r_wlen)) r_werr <= 1'b1;
        if (!f_in_range(r_waddr))        r_wdec <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------ storage
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rbyte;

    // One byte lane: strobed write and registered read-first port.
    always_ff @(posedge clock) begin
      if (w_wen && wstrb[gi]) r_mem[w_widx] <= wdata[gi*8 +: 8];
      if (w_rload)            r_rbyte       <= r_mem[w_ld_idx];
    end

    assign w_rword[gi*8 +: 8] = r_rbyte;
  end

endmodule

// File: tb/tb_ysyx_axi_sram.sv
// Directed bench for ysyx_axi_sram: inputs change and outputs are sampled on the falling edge.
module tb_ysyx_axi_sram;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] araddr = '0;
  logic [3:0]  arid = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [63:0] rdata;
  logic [3:0]  rid;
  logic [1:0]  rresp;
  logic        rlast;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] awaddr = '0;
  logic [3:0]  awid = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  bid;
  logic [1:0]  bresp;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] got_d [16];
  logic [1:0]  got_r [16];
  logic        got_l [16];
  logic [1:0]  b_resp;
  logic [3:0]  b_id;
  logic [63:0] d;

  ysyx_axi_sram dut (
    .clock(clock), .reset(reset),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid),
    .rresp(rresp), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("vec %0d %s obs=%h exp=%h", n_vec, tag, obs, exp);
  endtask

  task automatic ar_hs(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    araddr = a; arid = id; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    while (!arready && t < 50) begin @(negedge clock); t++; end
    chk("ar_ready", {63'd0, arready}, 64'd1);
    @(negedge clock);
    arvalid = 1'b0;
  endtask

  task automatic aw_hs(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    awaddr = a; awid = id; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    while (!awready && t < 50) begin @(negedge clock); t++; end
    chk("aw_ready", {63'd0, awready}, 64'd1);
    @(negedge clock);
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int t = 0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    while (!wready && t < 50) begin @(negedge clock); t++; end
    chk("w_ready", {63'd0, wready}, 64'd1);
    @(negedge clock);
    wvalid = 1'b0;
  endtask

  task automatic b_get();
    int t = 0;
    bready = 1'b1;
    while (!bvalid && t < 50) begin @(negedge clock); t++; end
    chk("b_valid", {63'd0, bvalid}, 64'd1);
    b_resp = bresp;
    b_id   = bid;
    @(negedge clock);
    bready = 1'b0;
  endtask

  task automatic rd_burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    ar_hs(a, id, len, size, burst);
    for (int b = 0; b <= int'(len); b++) begin
      int t = 0;
      while (!rvalid && t < 50) begin @(negedge clock); t++; end
      chk("r_valid", {63'd0, rvalid}, 64'd1);
      got_d[b] = rdata;
      got_r[b] = rresp;
      got_l[b] = rlast;
      rready = 1'b1;
      @(negedge clock);
      rready = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_arready", {63'd0, arready}, 64'd0);
    chk("rst_awready", {63'd0, awready}, 64'd0);
    chk("rst_rvalid",  {63'd0, rvalid},  64'd0);
    chk("rst_wready",  {63'd0, wready},  64'd0);
    chk("rst_bvalid",  {63'd0, bvalid},  64'd0);
    chk("rst_rlast",   {63'd0, rlast},   64'd0);
    chk("rst_rresp",   {62'd0, rresp},   64'd0);
    chk("rst_bresp",   {62'd0, bresp},   64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_arready", {63'd0, arready}, 64'd1);
    chk("post_rst_awready", {63'd0, awready}, 64'd1);

    // Single-beat write then read, with read latency check
    aw_hs(32'h8000_0000, 4'd5, 8'd0, 3'd3, 2'b01);
    w_beat(64'h1122_3344_5566_7788, 8'hFF, 1'b1);
    b_get();
    chk("wr1_bresp", {62'd0, b_resp}, 64'd0);
    chk("wr1_bid",   {60'd0, b_id},   64'd5);
    ar_hs(32'h8000_0000, 4'd3, 8'd0, 3'd3, 2'b01);
    chk("rd1_lat_c1", {63'd0, rvalid}, 64'd0);
    @(negedge clock);
    chk("rd1_lat_c2", {63'd0, rvalid}, 64'd1);
    chk("rd1_data",   rdata, 64'h1122_3344_5566_7788);
    chk("rd1_rlast",  {63'd0, rlast}, 64'd1);
    chk("rd1_rid",    {60'd0, rid},   64'd3);
    chk("rd1_rresp",  {62'd0, rresp}, 64'd0);
    rready = 1'b1;
    @(negedge clock);
    rready = 1'b0;
    chk("rd1_done_rvalid",  {63'd0, rvalid},  64'd0);
    chk("rd1_done_arready", {63'd0, arready}, 64'd1);

    // Partial strobe write
    aw_hs(32'h8000_0000, 4'd1, 8'd0, 3'd3, 2'b01);
    w_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b1);
    b_get();
    chk("strb_bresp", {62'd0, b_resp}, 64'd0);
    rd_burst(32'h8000_0000, 4'd1, 8'd0, 3'd3, 2'b01);
    chk("strb_data", got_d[0], 64'h1122_3344_FFFF_FFFF);

    // Four-beat INCR write, then read with rready toggling
    aw_hs(32'h8000_0100, 4'd1, 8'd3, 3'd3, 2'b01);
    for (int i = 0; i < 4; i++) w_beat(64'hA5A5_0000_0000_0000 + 64'(i), 8'hFF, i == 3);
    b_get();
    chk("burst_bresp", {62'd0, b_resp}, 64'd0);
    ar_hs(32'h8000_0100, 4'd2, 8'd3, 3'd3, 2'b01);
    for (int t = 0; t < 50 && !rvalid; t++) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      d = 64'hA5A5_0000_0000_0000 + 64'(i);
      chk("b4_rvalid",  {63'd0, rvalid},  64'd1);
      chk("b4_data",    rdata, d);
      chk("b4_rlast",   {63'd0, rlast}, {63'd0, i == 3});
      chk("b4_arready", {63'd0, arready}, 64'd0);
      chk("b4_rid",     {60'd0, rid}, 64'd2);
      @(negedge clock);
      chk("b4_stall_valid", {63'd0, rvalid}, 64'd1);
      chk("b4_stall_data",  rdata, d);
      chk("b4_stall_rlast", {63'd0, rlast}, {63'd0, i == 3});
      rready = 1'b1;
      @(negedge clock);
      rready = 1'b0;
    end
    chk("b4_end_rvalid",  {63'd0, rvalid},  64'd0);
    chk("b4_end_arready", {63'd0, arready}, 64'd1);

    // Narrow INCR (size 2) stays in the same word; FIXED repeats the word
    rd_burst(32'h8000_0100, 4'd4, 8'd1, 3'd2, 2'b01);
    chk("narrow_b0", got_d[0], 64'hA5A5_0000_0000_0000);
    chk("narrow_b1", got_d[1], 64'hA5A5_0000_0000_0000);
    rd_burst(32'h8000_0108, 4'd4, 8'd1, 3'd3, 2'b00);
    chk("fixed_b0", got_d[0], 64'hA5A5_0000_0000_0001);
    chk("fixed_b1", got_d[1], 64'hA5A5_0000_0000_0001);

    // Out-of-range read: DECERR, zero data
    rd_burst(32'h0000_1000, 4'd6, 8'd1, 3'd3, 2'b01);
    chk("dec_r0",    {62'd0, got_r[0]}, 64'd3);
    chk("dec_d0",    got_d[0], 64'd0);
    chk("dec_r1",    {62'd0, got_r[1]}, 64'd3);
    chk("dec_d1",    got_d[1], 64'd0);
    chk("dec_last0", {63'd0, got_l[0]}, 64'd0);
    chk("dec_last1", {63'd0, got_l[1]}, 64'd1);

    // Burst straddling the top of the window
    rd_burst(32'h8000_7FF8, 4'd7, 8'd1, 3'd3, 2'b01);
    chk("edge_r0", {62'd0, got_r[0]}, 64'd0);
    chk("edge_r1", {62'd0, got_r[1]}, 64'd3);
    chk("edge_d1", got_d[1], 64'd0);

    // WRAP read: SLVERR, zero data
    rd_burst(32'h8000_0000, 4'd1, 8'd1, 3'd3, 2'b10);
    chk("wrap_rd_r0", {62'd0, got_r[0]}, 64'd2);
    chk("wrap_rd_r1", {62'd0, got_r[1]}, 64'd2);
    chk("wrap_rd_d0", got_d[0], 64'd0);

    // WRAP write: SLVERR, memory untouched
    aw_hs(32'h8000_0000, 4'd9, 8'd0, 3'd3, 2'b10);
    w_beat(64'd0, 8'hFF, 1'b1);
    b_get();
    chk("wrap_wr_bresp", {62'd0, b_resp}, 64'd2);
    chk("wrap_wr_bid",   {60'd0, b_id},   64'd9);
    rd_burst(32'h8000_0000, 4'd1, 8'd0, 3'd3, 2'b01);
    chk("wrap_wr_keep", got_d[0], 64'h1122_3344_FFFF_FFFF);

    // Out-of-range write: DECERR
    aw_hs(32'h0000_1000, 4'd2, 8'd0, 3'd3, 2'b01);
    w_beat(64'h5555_5555_5555_5555, 8'hFF, 1'b1);
    b_get();
    chk("dec_wr_bresp", {62'd0, b_resp}, 64'd3);

    // Early wlast: burst still takes two beats, response is SLVERR
    aw_hs(32'h8000_0200, 4'hA, 8'd1, 3'd3, 2'b01);
    w_beat(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
    chk("early_wready", {63'd0, wready}, 64'd1);
    chk("early_bvalid", {63'd0, bvalid}, 64'd0);
    w_beat(64'hFEDC_BA98_7654_3210, 8'hFF, 1'b1);
    b_get();
    chk("early_bresp", {62'd0, b_resp}, 64'd2);
    chk("early_bid",   {60'd0, b_id},   64'hA);
    rd_burst(32'h8000_0200, 4'd0, 8'd1, 3'd3, 2'b01);
    chk("early_d0", got_d[0], 64'h0123_4567_89AB_CDEF);
    chk("early_d1", got_d[1], 64'hFEDC_BA98_7654_3210);

    // Reset in the middle of an eight-beat read
    ar_hs(32'h8000_0100, 4'd3, 8'd7, 3'd3, 2'b01);
    for (int t = 0; t < 50 && !rvalid; t++) @(negedge clock);
    rready = 1'b1;
    @(negedge clock);
    rready = 1'b0;
    chk("mid_rvalid", {63'd0, rvalid}, 64'd1);
    chk("mid_data",   rdata, 64'hA5A5_0000_0000_0001);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_rvalid",  {63'd0, rvalid},  64'd0);
    chk("mid_rst_arready", {63'd0, arready}, 64'd0);
    chk("mid_rst_awready", {63'd0, awready}, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_post_arready", {63'd0, arready}, 64'd1);
    chk("mid_post_awready", {63'd0, awready}, 64'd1);
    rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("mid_post_rvalid", {63'd0, rvalid}, 64'd0);
      chk("mid_post_bvalid", {63'd0, bvalid}, 64'd0);
      @(negedge clock);
    end
    rready = 1'b0;

    // Memory survives reset
    rd_burst(32'h8000_0000, 4'd1, 8'd0, 3'd3, 2'b01);
    chk("after_rst_data", got_d[0], 64'h1122_3344_FFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
